// File: rtl/msg_scroll_scan.sv
// ---------------------------------------------------------------------------
// msg_scroll_scan
//
// Purpose:
//   Feeds the 5-bit character-code to 7-segment decoder of the pet-status
//   display. Holds a ROM of four status messages (FELIZ, HAMBRE, TRISTE,
//   SUEnO; codes 4..7 are blank), scrolls the selected message across
//   NUM_DIG multiplexed digits and time-multiplexes the digits. It presents
//   one character code and one active-low anode per refresh slot.
//
// Parameters:
//   NUM_DIG      number of scanned digits (2..8)
//   REFRESH_DIV  clk cycles per digit slot
//   SCROLL_DIV   clk cycles per one-character scroll step
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   msg_sel    message select (0 FELIZ, 1 HAMBRE, 2 TRISTE, 3 SUEnO, 4..7 blank)
//   scroll_en  1 = scroll, 0 = hold the window at position 0
//   hold       (only with SCROLL_HOLD_EN) freezes the scroll position
//   bcd        character code for the enabled digit
//   an         active-low one-hot digit enable; digit 0 is the MSB
//
// Build option:
//   SCROLL_HOLD_EN  adds the hold input
// ---------------------------------------------------------------------------
module msg_scroll_scan #(
    parameter int NUM_DIG     = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int SCROLL_DIV  = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         msg_sel,
    input  logic               scroll_en,
`ifdef SCROLL_HOLD_EN
    input  logic               hold,
`endif
    output logic [4:0]         bcd,
    output logic [NUM_DIG-1:0] an
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (SCROLL_DIV  > 1) ? $clog2(SCROLL_DIV)  : 1;
    localparam int DW = $clog2(NUM_DIG);

    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] SCR_LAST = SW'(SCROLL_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIG - 1);

    // Messages packed with slot 0 in the least significant 5 bits.
    localparam logic [39:0] MSG_FELIZ  = {5'd31, 5'd31, 5'd31, 5'd4,  5'd3,  5'd2,  5'd1,  5'd0};
    localparam logic [39:0] MSG_HAMBRE = {5'd31, 5'd31, 5'd1,  5'd8,  5'd13, 5'd12, 5'd11, 5'd10};
    localparam logic [39:0] MSG_TRISTE = {5'd31, 5'd31, 5'd1,  5'd7,  5'd15, 5'd3,  5'd8,  5'd7};
    localparam logic [39:0] MSG_SUENO  = {5'd31, 5'd31, 5'd31, 5'd9,  5'd5,  5'd1,  5'd6,  5'd15};

    function automatic logic [4:0] rom_char(input logic [2:0] m, input logic [2:0] s);
        logic [4:0] c;
        case (m)
            3'd0:    c = MSG_FELIZ[5*s +: 5];
            3'd1:    c = MSG_HAMBRE[5*s +: 5];
            3'd2:    c = MSG_TRISTE[5*s +: 5];
            3'd3:    c = MSG_SUENO[5*s +: 5];
            default: c = 5'd31;
        endcase
        return c;
    endfunction

    logic [RW-1:0]      ref_cnt_q, ref_cnt_d;
    logic [SW-1:0]      scr_cnt_q, scr_cnt_d;
    logic [DW-1:0]      dig_q, dig_d;     // index of the digit shown at the next tick
    logic [2:0]         pos_q, pos_d;
    logic [2:0]         msg_q;
    logic [NUM_DIG-1:0] an_q, an_d;
    logic [4:0]         bcd_q, bcd_d;
    logic [NUM_DIG-1:0] an_sel;
    logic               tick;
    logic               msg_chg;
    logic               hold_w;

`ifdef SCROLL_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    assign tick    = (ref_cnt_q == REF_LAST);
    assign msg_chg = (msg_sel != msg_q);

    // Digit k drives anode bit NUM_DIG-1-k low.
    generate
        for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_an
            assign an_sel[gi] = (dig_q != DW'(NUM_DIG - 1 - gi));
        end
    endgenerate

    always_comb begin
        ref_cnt_d = tick ? '0 : ref_cnt_q + 1'b1;
        dig_d     = dig_q;
        an_d      = an_q;
        bcd_d     = bcd_q;
        if (tick) begin
            dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
            an_d  = an_sel;
            // msg_q and pos_q are updated together, so a message switch
            // never mixes the old position with the new text.
            bcd_d = rom_char(msg_q, pos_q + 3'(dig_q));
        end

        pos_d     = pos_q;
        scr_cnt_d = scr_cnt_q;
        if (msg_chg || !scroll_en) begin
            // A message switch outranks both a scroll step and hold.
            pos_d     = '0;
            scr_cnt_d = '0;
        end else if (!hold_w) begin
            if (scr_cnt_q == SCR_LAST) begin
                scr_cnt_d = '0;
                pos_d     = pos_q + 3'd1;
            end else begin
                scr_cnt_d = scr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q <= '0;
            scr_cnt_q <= '0;
            dig_q     <= '0;
            pos_q     <= '0;
            msg_q     <= '0;
            an_q      <= '1;
            bcd_q     <= 5'd31;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            scr_cnt_q <= scr_cnt_d;
            dig_q     <= dig_d;
            pos_q     <= pos_d;
            msg_q     <= msg_sel;
            an_q      <= an_d;
            bcd_q     <= bcd_d;
        end
    end

    assign an  = an_q;
    assign bcd = bcd_q;

endmodule

// File: tb/tb_msg_scroll_scan.sv
// ---------------------------------------------------------------------------
// tb_msg_scroll_scan
//
// Self-checking bench for msg_scroll_scan with NUM_DIG=4, REFRESH_DIV=4 and
// SCROLL_DIV=64. The reference model tracks the number of edges since reset
// and the number of counted scroll cycles since the last clear. It derives
// the slot digit and the scroll position from these counts arithmetically.
// Define SCROLL_HOLD_EN to build and exercise the hold input.
// ---------------------------------------------------------------------------
module tb_msg_scroll_scan;

    localparam int NDIG = 4;
    localparam int RDIV = 4;
    localparam int SDIV = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] msg_sel = 3'd0;
    logic       scroll_en = 1'b0;
    logic       hold = 1'b0;
    logic [4:0] bcd;
    logic [3:0] an;

    int n_assert = 0;
    int n_fail   = 0;

    msg_scroll_scan #(
        .NUM_DIG    (NDIG),
        .REFRESH_DIV(RDIV),
        .SCROLL_DIV (SDIV)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .msg_sel  (msg_sel),
        .scroll_en(scroll_en),
`ifdef SCROLL_HOLD_EN
        .hold     (hold),
`endif
        .bcd      (bcd),
        .an       (an)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int rom [0:7][0:7];

    int         m_n;     // clock edges since reset release
    int         m_run;   // counted scroll cycles since the last clear
    logic [2:0] m_msg;   // message latched on the previous edge
    logic [3:0] m_an;
    logic [4:0] m_bcd;

    function automatic int mpos(input int run);
        return (run / SDIV) % 8;
    endfunction

    function automatic logic [3:0] exp_an(input int k);
        logic [3:0] a;
        a = 4'hF;
        a[NDIG-1-k] = 1'b0;
        return a;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n   <= 0;
            m_run <= 0;
            m_msg <= 3'd0;
            m_an  <= 4'hF;
            m_bcd <= 5'd31;
        end else begin
            m_n <= m_n + 1;
            if ((m_n + 1) % RDIV == 0) begin
                m_an  <= exp_an(((m_n + 1) / RDIV - 1) % NDIG);
                m_bcd <= 5'(rom[m_msg][(mpos(m_run) + ((m_n + 1) / RDIV - 1) % NDIG) % 8]);
            end
            if (msg_sel != m_msg || !scroll_en)
                m_run <= 0;
            else if (!hold)
                m_run <= m_run + 1;
            m_msg <= msg_sel;
        end
    end

    // Waits until a freshly loaded digit-0 slot appears; ok=0 on timeout.
    task automatic wait_slot0(output bit ok);
        int t;
        ok = 1'b0;
        t  = 0;
        while (an == 4'b0111 && t < 40) begin @(negedge clk); t++; end
        while (an != 4'b0111 && t < 40) begin @(negedge clk); t++; end
        ok = (an == 4'b0111);
    endtask

    // Waits until the model scroll position equals p; ok=0 on timeout.
    task automatic wait_pos(input int p, output bit ok);
        int t;
        t = 0;
        while (mpos(m_run) != p && t < 1200) begin @(negedge clk); t++; end
        ok = (mpos(m_run) == p);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; msg_sel = 3'd0; scroll_en = 1'b0;
        #1;
        n_assert++;
        if (an !== 4'b1111 || bcd !== 5'd31) begin
            n_fail++;
            $display("FAIL reset_state: an=%b bcd=%0d required an=1111 bcd=31", an, bcd);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_assert++;
        if (an !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_pre_tick: an=%b required 1111", an);
        end
        @(negedge clk);
        n_assert++;
        if (an !== 4'b0111 || bcd !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_first_tick: an=%b bcd=%0d required an=0111 bcd=0", an, bcd);
        end
        $display("reset: an=%b bcd=%0d after first tick", an, bcd);
    endtask

    task automatic test_static_scan();
        bit ok;
        logic [4:0] exp_b [0:3];
        exp_b = '{5'd0, 5'd1, 5'd2, 5'd3};
        msg_sel = 3'd0; scroll_en = 1'b0;
        wait_slot0(ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL static_wait: an=%b required 0111 within bound", an); end
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 4; c++) begin
                    n_assert++;
                    if (an !== exp_an(d) || bcd !== exp_b[d]) begin
                        n_fail++;
                        $display("FAIL static_scan: rep=%0d digit=%0d cycle=%0d an=%b bcd=%0d required an=%b bcd=%0d",
                                 r, d, c, an, bcd, exp_an(d), exp_b[d]);
                    end
                    @(negedge clk);
                end
            end
        end
        $display("static_scan: FELIZ held 4 cycles per digit over 2 rounds");
    endtask

    // Checks four consecutive slots starting from a fresh digit-0 slot.
    task automatic test_window(input string name, input logic [4:0] e0, input logic [4:0] e1,
                               input logic [4:0] e2, input logic [4:0] e3);
        bit ok;
        logic [4:0] exp_b [0:3];
        exp_b = '{e0, e1, e2, e3};
        wait_slot0(ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL %s_wait: an=%b required 0111 within bound", name, an); end
        for (int d = 0; d < 4; d++) begin
            n_assert++;
            if (an !== exp_an(d) || bcd !== exp_b[d]) begin
                n_fail++;
                $display("FAIL %s: digit=%0d an=%b bcd=%0d required an=%b bcd=%0d",
                         name, d, an, bcd, exp_an(d), exp_b[d]);
            end
            repeat (4) @(negedge clk);
        end
        $display("%s: window %0d %0d %0d %0d", name, e0, e1, e2, e3);
    endtask

    task automatic test_scroll();
        bit ok;
        msg_sel = 3'd1; scroll_en = 1'b1;
        wait_pos(3, ok);
        n_assert++;
        if (!ok || u_dut.pos_q !== 3'd3) begin
            n_fail++;
            $display("FAIL scroll_pos3: pos=%0d required 3", u_dut.pos_q);
        end
        test_window("scroll_pos3", 5'd13, 5'd8, 5'd1, 5'd31);
        wait_pos(6, ok);
        n_assert++;
        if (!ok || u_dut.pos_q !== 3'd6) begin
            n_fail++;
            $display("FAIL scroll_pos6: pos=%0d required 6", u_dut.pos_q);
        end
        test_window("scroll_pos6", 5'd31, 5'd31, 5'd10, 5'd11);
    endtask

    task automatic test_msg_switch();
        bit ok;
        wait_pos(5, ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL switch_wait: pos=%0d required 5", u_dut.pos_q); end
        msg_sel = 3'd2;
        @(negedge clk);
        n_assert++;
        if (u_dut.pos_q !== 3'd0 || u_dut.scr_cnt_q !== 6'd0) begin
            n_fail++;
            $display("FAIL switch_clear: pos=%0d cnt=%0d required 0 0", u_dut.pos_q, u_dut.scr_cnt_q);
        end
        test_window("switch_triste", 5'd7, 5'd8, 5'd3, 5'd15);
    endtask

    task automatic test_simultaneous();
        int t;
        t = 0;
        while ((m_run % SDIV) != SDIV - 1 && t < 200) begin @(negedge clk); t++; end
        n_assert++;
        if (u_dut.scr_cnt_q !== 6'd63) begin
            n_fail++;
            $display("FAIL simul_terminal: cnt=%0d required 63", u_dut.scr_cnt_q);
        end
        msg_sel = 3'd3;
        @(negedge clk);
        n_assert++;
        if (u_dut.pos_q !== 3'd0) begin
            n_fail++;
            $display("FAIL simul_clear: pos=%0d required 0", u_dut.pos_q);
        end
        test_window("simul_sueno", 5'd15, 5'd6, 5'd1, 5'd5);
    endtask

`ifdef SCROLL_HOLD_EN
    task automatic test_hold();
        bit ok;
        int changes;
        logic [2:0] p0;
        logic [3:0] prev;
        msg_sel = 3'd1; scroll_en = 1'b1;
        wait_pos(2, ok);
        repeat (20) @(negedge clk);
        hold = 1'b1;
        @(negedge clk);
        p0 = u_dut.pos_q;
        prev = an;
        changes = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (an != prev) changes++;
            prev = an;
        end
        n_assert++;
        if (u_dut.pos_q !== p0 || 3'(mpos(m_run)) !== p0) begin
            n_fail++;
            $display("FAIL hold_freeze: pos=%0d required %0d", u_dut.pos_q, p0);
        end
        n_assert++;
        if (changes < 45) begin
            n_fail++;
            $display("FAIL hold_scan: an changes=%0d required >=45", changes);
        end
        hold = 1'b0;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            n_assert++;
            if (u_dut.pos_q !== 3'(mpos(m_run))) begin
                n_fail++;
                $display("FAIL hold_resume: cycle=%0d pos=%0d required %0d", c, u_dut.pos_q, mpos(m_run));
            end
        end
        $display("hold: pos frozen at %0d, %0d scan changes", p0, changes);
    endtask
`endif

    task automatic test_reset_mid();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_assert++;
        if (an !== 4'b1111 || bcd !== 5'd31) begin
            n_fail++;
            $display("FAIL reset_mid: an=%b bcd=%0d required an=1111 bcd=31", an, bcd);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_assert++;
        if (an !== 4'b0111 || bcd !== 5'(rom[msg_sel][0])) begin
            n_fail++;
            $display("FAIL reset_mid_restart: an=%b bcd=%0d required an=0111 bcd=%0d", an, bcd, rom[msg_sel][0]);
        end
        $display("reset_mid: restart an=%b bcd=%0d", an, bcd);
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            n_assert++;
            if (an !== m_an || bcd !== m_bcd) begin
                n_fail++; bad++;
                if (bad < 10)
                    $display("FAIL random: cycle=%0d an=%b bcd=%0d required an=%b bcd=%0d",
                             c, an, bcd, m_an, m_bcd);
            end
            if ($urandom_range(0, 79) == 0) msg_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) scroll_en = ($urandom_range(0, 3) != 0);
        end
        $display("random: 1500 cycles compared against model, %0d bad", bad);
    endtask

    initial begin
        rom[0] = '{0, 1, 2, 3, 4, 31, 31, 31};
        rom[1] = '{10, 11, 12, 13, 8, 1, 31, 31};
        rom[2] = '{7, 8, 3, 15, 7, 1, 31, 31};
        rom[3] = '{15, 6, 1, 5, 9, 31, 31, 31};
        for (int m = 4; m < 8; m++)
            for (int s = 0; s < 8; s++) rom[m][s] = 31;

        test_reset();
        test_static_scan();
        test_scroll();
        test_msg_switch();
        test_simultaneous();
`ifdef SCROLL_HOLD_EN
        test_hold();
`endif
        msg_sel = 3'd1; scroll_en = 1'b1;
        test_random();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
